// File: rtl/tmds_pll_lock_sequencer.sv
// tmds_pll_lock_sequencer
//
// Brings up the TMDS PLLVR and keeps it locked. The block runs on the
// free-running 27 MHz reference clock, never on a PLL output, so it keeps
// working while the PLL is in reset or unlocked.
//
// Operation:
//   - Holds the PLL in reset for RST_CYCLES cycles.
//   - Waits for a synchronized LOCK to stay high for LOCK_STABLE consecutive
//     cycles. If LOCK_TIMEOUT cycles pass first, the PLL is retried.
//   - Once lock is qualified, releases the TMDS serializer and pixel reset.
//   - Lock loss in RUN, or a software relock pulse, restarts the sequence.
//
// Ports:
//   I_clk        27 MHz reference clock (same net as PLL CLKIN)
//   I_rst_n      asynchronous active-low reset
//   I_pll_lock   PLLVR LOCK, asynchronous to I_clk
//   I_relock     one-cycle pulse: force a full PLL reset sequence
//   O_pll_reset  to PLLVR RESET; high holds the PLL in reset
//   O_sys_rst_n  active-low reset for the TMDS/pixel logic
//   O_ready      high only in RUN
//   O_retry_cnt  failed-lock events, saturating at 255
//   O_state      00 RST_PLL, 01 WAIT_LOCK, 10 RUN
module tmds_pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 270000,
  parameter int CNT_W        = 20
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_pll_lock,
  input  logic       I_relock,
  output logic       O_pll_reset,
  output logic       O_sys_rst_n,
  output logic       O_ready,
  output logic [7:0] O_retry_cnt,
  output logic [1:0] O_state
);

  localparam logic [1:0] ST_RST_PLL   = 2'b00;
  localparam logic [1:0] ST_WAIT_LOCK = 2'b01;
  localparam logic [1:0] ST_RUN       = 2'b10;

  // Terminal values: a counter sitting at its "last" value on an edge means
  // the target count is reached on that edge.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;    // RST_PLL hold count, or WAIT_LOCK timeout
  logic [CNT_W-1:0] stab, stab_nxt;  // consecutive synced-lock-high cycles
  logic             lock_meta, lock_s;
  logic [7:0]       retry, retry_nxt;
  logic             fail;
  logic             stab_hit, tmo_hit;
  logic             pll_reset_nxt, sys_rst_n_nxt, ready_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // State register, counters, lock synchronizer and registered outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state       <= ST_RST_PLL;
      cnt         <= '0;
      stab        <= '0;
      retry       <= 8'd0;
      O_pll_reset <= 1'b1;
      O_sys_rst_n <= 1'b0;
      O_ready     <= 1'b0;
    end else begin
      lock_meta   <= I_pll_lock;
      lock_s      <= lock_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      stab        <= stab_nxt;
      retry       <= retry_nxt;
      O_pll_reset <= pll_reset_nxt;
      O_sys_rst_n <= sys_rst_n_nxt;
      O_ready     <= ready_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    stab_nxt  = '0;
    fail      = 1'b0;
    stab_hit  = lock_s && (stab == STAB_LAST);
    tmo_hit   = (cnt == TMO_LAST);
    case (state)
      ST_RST_PLL: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
        else                 cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_WAIT_LOCK: begin
        // Stable lock takes priority over a timeout on the same edge.
        if (stab_hit) begin
          state_nxt = ST_RUN;
        end else if (tmo_hit) begin
          state_nxt = ST_RST_PLL;
          fail      = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          stab_nxt = lock_s ? stab + CNT_W'(1) : '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_RST_PLL;
          fail      = 1'b1;
        end
      end
      default: state_nxt = ST_RST_PLL;
    endcase
    // Relock overrides the destination, but a failure detected on the same
    // edge is still counted.
    if (I_relock) begin
      state_nxt = ST_RST_PLL;
      cnt_nxt   = '0;
      stab_nxt  = '0;
    end
    retry_nxt = fail ? sat_inc8(retry) : retry;
  end

  // Output decode, from the next state so that every output is registered
  always_comb begin
    pll_reset_nxt = (state_nxt == ST_RST_PLL);
    sys_rst_n_nxt = (state_nxt == ST_RUN);
    ready_nxt     = (state_nxt == ST_RUN);
  end

  assign O_retry_cnt = retry;
  assign O_state     = state;

endmodule

// File: tb/tb_tmds_pll_lock_sequencer.sv
module tb_tmds_pll_lock_sequencer;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int CNT_W        = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       relock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [1:0] state;

  tmds_pll_lock_sequencer #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_pll_lock (pll_lock),
    .I_relock   (relock),
    .O_pll_reset(pll_reset),
    .O_sys_rst_n(sys_rst_n),
    .O_ready    (ready),
    .O_retry_cnt(retry_cnt),
    .O_state    (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {pll_reset, sys_rst_n, ready, retry[7:0], state[1:0]} per edge
  logic [12:0] sbq[$];

  // Reference model: phase 0 = hold PLL in reset, 1 = waiting for lock,
  // 2 = running. m_t = cycles spent in the phase so far.
  int m_phase, m_t, m_retry;
  bit lin[$];  // raw lock input seen at each edge since reset release

  logic       seen_sys;
  logic [7:0] seen_retry;
  logic [1:0] seen_state;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_retry = 0;
    lin.delete();
  endtask

  task automatic model_edge(input bit l, input bit r);
    bit ls, ok, tmo, fail;
    int idx;
    lin.push_back(l);
    if (lin.size() > 64) void'(lin.pop_front());
    // The synchronizer makes the FSM see the input from two edges earlier.
    ls   = (lin.size() >= 3) ? lin[lin.size()-3] : 1'b0;
    fail = 1'b0;
    case (m_phase)
      0: begin
        if (r)                           m_t = 0;
        else if (m_t == RST_CYCLES - 1) begin m_phase = 1; m_t = 0; end
        else                             m_t++;
      end
      1: begin
        // Lock qualifies when the last LOCK_STABLE synced samples, all taken
        // inside this waiting phase, were high.
        ok = (m_t + 1 >= LOCK_STABLE);
        for (int i = 0; i < LOCK_STABLE; i++) begin
          idx = lin.size() - 3 - i;
          if (idx < 0) ok = 1'b0;
          else if (!lin[idx]) ok = 1'b0;
        end
        tmo  = (m_t + 1 == LOCK_TIMEOUT);
        fail = tmo && !ok;
        if (r)        begin m_phase = 0; m_t = 0; end
        else if (ok)  begin m_phase = 2; m_t = 0; end
        else if (tmo) begin m_phase = 0; m_t = 0; end
        else          m_t++;
      end
      default: begin
        fail = !ls;
        if (r || fail) begin m_phase = 0; m_t = 0; end
      end
    endcase
    if (fail && m_retry < 255) m_retry++;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the
  // following rising edge.
  task automatic step(input bit l, input bit r);
    @(negedge clk);
    #1;
    seen_sys   = sys_rst_n;
    seen_retry = retry_cnt;
    seen_state = state;
    pll_lock   = l;
    relock     = r;
    model_edge(l, r);
    sbq.push_back({m_phase == 0, m_phase == 2, m_phase == 2,
                   8'(m_retry), 2'(m_phase)});
  endtask

  // Monitor: compares every edge that has a queued expectation.
  initial begin
    logic [12:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        exp_v = sbq.pop_front();
        act_v = {pll_reset, sys_rst_n, ready, retry_cnt, state};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL sb_cycle t=%0t actual pll_reset=%b sys_rst_n=%b ready=%b retry=%0d state=%b required pll_reset=%b sys_rst_n=%b ready=%b retry=%0d state=%b",
                   $time, act_v[12], act_v[11], act_v[10], act_v[9:2], act_v[1:0],
                   exp_v[12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1:0]);
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) ready |-> (sys_rst_n && !pll_reset))
    else begin
      errors++;
      $display("FAIL sva_ready_implies_run actual sys_rst_n=%b pll_reset=%b required 1 0",
               sys_rst_n, pll_reset);
    end

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"}, int'(pll_reset), 1);
    check({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
    check({tag, "_ready"},     int'(ready),     0);
    check({tag, "_retry"},     int'(retry_cnt), 0);
    check({tag, "_state"},     int'(state),     0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 && sbq.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_queue_left"}, sbq.size(), 0);
  endtask

  initial begin
    int rise, s1, s2, s3, guard;
    bit lk;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    relock   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");

    // Power-up: lock rises as soon as the PLL leaves reset.
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (RST_CYCLES) step(0, 0);
    rise = -1;
    for (int j = 1; j <= 16; j++) begin
      step(1, 0);
      if (rise < 0 && seen_sys) rise = j - 1;
    end
    check("t1_release_latency", rise, LOCK_STABLE + 2);
    check("t1_state_run", int'(seen_state), 2);
    check("t1_retry_zero", int'(seen_retry), 0);

    // Lock glitch one cycle before qualification restarts the window.
    step(1, 1);
    guard = 0;
    while (m_phase != 1 && guard < 20) begin step(1, 0); guard++; end
    check("t3_reached_wait", m_phase, 1);
    rise = -1;
    for (int j = 1; j <= 24; j++) begin
      step(j != 6, 0);
      if (rise < 0 && seen_sys) rise = j - 1;
    end
    check("t3_release_after_glitch", rise, 2 * LOCK_STABLE);

    // Lock loss in RUN: reset reaches the pixel domain on the third edge.
    step(0, 0);
    step(0, 0); s1 = int'(seen_sys);
    step(0, 0); s2 = int'(seen_sys);
    step(0, 0); s3 = int'(seen_sys);
    check("t4_sys_after_1", s1, 1);
    check("t4_sys_after_2", s2, 1);
    check("t4_sys_after_3", s3, 0);
    repeat (30) step(1, 0);
    check("t4_relocked_run", int'(seen_state), 2);

    // Relock in RUN, in RST_PLL at count 2, and coincident with a timeout.
    step(1, 1);
    guard = 0;
    while (!(m_phase == 0 && m_t == 2) && guard < 20) begin step(1, 0); guard++; end
    step(1, 1);
    guard = 0;
    while (!(m_phase == 1 && m_t == LOCK_TIMEOUT - 1) && guard < 100) begin
      step(0, 0);
      guard++;
    end
    check("t5_reached_timeout_edge", m_t, LOCK_TIMEOUT - 1);
    step(0, 1);
    repeat (30) step(1, 0);
    check("t5_back_in_run", int'(seen_state), 2);

    // Random lock behaviour with occasional relock pulses.
    lk = 1'b1;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 23) == 0) lk = !lk;
      step(lk, $urandom_range(0, 99) == 0);
    end

    // Lock never comes: retry counter climbs and saturates.
    for (int j = 0; j < 300 * (RST_CYCLES + LOCK_TIMEOUT) + 40; j++) step(0, 0);
    check("t2_retry_saturated", int'(seen_retry), 255);

    // Asynchronous reset in the middle of RUN.
    repeat (30) step(1, 0);
    check("t6_in_run", int'(seen_state), 2);
    drain("t6");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (RST_CYCLES + LOCK_STABLE + 8) step(1, 0);
    check("t6_restart_run", int'(seen_state), 2);

    step(1, 0);
    drain("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
